// File: rtl/fft_top_requant_pkg.sv
// Shared defaults, output limits and complex beat types for the FFT product requantizer.
// Optional overflow event counter is enabled by defining FFT_TOP_REQUANT_OVF_CNT_EN.
package fft_top_requant_pkg;

  localparam int unsigned DIN_WIDTH_DEF  = 39;
  localparam int unsigned DOUT_WIDTH_DEF = 24;
  localparam int unsigned SHIFT_DEF      = 15;
  localparam int unsigned CNT_WIDTH_DEF  = 16;

  localparam logic [DOUT_WIDTH_DEF-1:0] OUT_MAX = {1'b0, {(DOUT_WIDTH_DEF-1){1'b1}}};
  localparam logic [DOUT_WIDTH_DEF-1:0] OUT_MIN = {1'b1, {(DOUT_WIDTH_DEF-1){1'b0}}};

  typedef struct packed {
    logic [DIN_WIDTH_DEF-1:0] re;
    logic [DIN_WIDTH_DEF-1:0] im;
  } cplx_in_t;

  typedef struct packed {
    logic [DOUT_WIDTH_DEF-1:0] re;
    logic [DOUT_WIDTH_DEF-1:0] im;
  } cplx_out_t;

endpackage

// File: rtl/fft_top_round_sat.sv
// One lane of requantization: arithmetic shift, round-half-to-even, saturate.
// Purely combinational; ovf_o flags that the clamp was applied.
module fft_top_round_sat
  import fft_top_requant_pkg::*;
#(
  parameter int unsigned DIN_WIDTH  = DIN_WIDTH_DEF,
  parameter int unsigned DOUT_WIDTH = DOUT_WIDTH_DEF,
  parameter int unsigned SHIFT      = SHIFT_DEF
) (
  input  logic [DIN_WIDTH-1:0]  x_i,
  output logic [DOUT_WIDTH-1:0] y_o,
  output logic                  ovf_o
);

  // One guard bit above the shifted value so the +1 round-up can never wrap.
  localparam int unsigned RW = DIN_WIDTH - SHIFT + 1;
  localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);

  logic [RW-1:0]    t_ext;
  logic [RW-1:0]    r;
  logic [SHIFT-1:0] frac;
  logic             round_up;

  always_comb begin
    t_ext    = {x_i[DIN_WIDTH-1], x_i[DIN_WIDTH-1:SHIFT]};
    frac     = x_i[SHIFT-1:0];
    round_up = (frac > HALF) || ((frac == HALF) && t_ext[0]);
    r        = t_ext + RW'(round_up);
  end

  if (RW > DOUT_WIDTH) begin : g_sat
    logic [RW-DOUT_WIDTH:0] top_bits;

    // In range only when every bit from the output sign bit upward agrees.
    assign top_bits = r[RW-1:DOUT_WIDTH-1];
    assign ovf_o    = !((&top_bits) || !(|top_bits));

    always_comb begin
      y_o = r[DOUT_WIDTH-1:0];
      if (ovf_o) begin
        y_o = r[RW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}} : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
      end
    end
  end else begin : g_nosat
    assign ovf_o = 1'b0;
    assign y_o   = DOUT_WIDTH'($signed(r));
  end

endmodule

// File: rtl/fft_top_prod_requant.sv
// Two-stage valid/ready requantizer returning DSP products to the 24-bit FFT datapath.
// Define FFT_TOP_REQUANT_OVF_CNT_EN to add the saturating ovf_count event counter.
module fft_top_prod_requant
  import fft_top_requant_pkg::*;
#(
  parameter int unsigned DIN_WIDTH  = DIN_WIDTH_DEF,
  parameter int unsigned DOUT_WIDTH = DOUT_WIDTH_DEF,
  parameter int unsigned SHIFT      = SHIFT_DEF
`ifdef FFT_TOP_REQUANT_OVF_CNT_EN
  ,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DIN_WIDTH-1:0]  s_re,
  input  logic [DIN_WIDTH-1:0]  s_im,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DOUT_WIDTH-1:0] m_re,
  output logic [DOUT_WIDTH-1:0] m_im,
  input  logic                  ovf_clear,
  output logic                  ovf_sticky
`ifdef FFT_TOP_REQUANT_OVF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  ovf_count
`endif
);

  logic                  en;
  logic                  s1_valid_q, s1_valid_d;
  logic [DIN_WIDTH-1:0]  s1_re_q, s1_re_d;
  logic [DIN_WIDTH-1:0]  s1_im_q, s1_im_d;
  logic                  m_valid_q, m_valid_d;
  logic [DOUT_WIDTH-1:0] m_re_q, m_re_d;
  logic [DOUT_WIDTH-1:0] m_im_q, m_im_d;
  logic [DOUT_WIDTH-1:0] rs_re, rs_im;
  logic                  ovf_re, ovf_im, ovf_evt;
  logic                  sticky_q, sticky_d;

  // Whole pipeline moves as one; a stall freezes both stages.
  assign en      = !m_valid_q || m_ready;
  assign s_ready = en;

  fft_top_round_sat #(
    .DIN_WIDTH  (DIN_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH),
    .SHIFT      (SHIFT)
  ) u_rs_re (
    .x_i   (s1_re_q),
    .y_o   (rs_re),
    .ovf_o (ovf_re)
  );

  fft_top_round_sat #(
    .DIN_WIDTH  (DIN_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH),
    .SHIFT      (SHIFT)
  ) u_rs_im (
    .x_i   (s1_im_q),
    .y_o   (rs_im),
    .ovf_o (ovf_im)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_re_d    = s1_re_q;
    s1_im_d    = s1_im_q;
    m_valid_d  = m_valid_q;
    m_re_d     = m_re_q;
    m_im_d     = m_im_q;
    if (en) begin
      s1_valid_d = s_valid;
      if (s_valid) begin
        s1_re_d = s_re;
        s1_im_d = s_im;
      end
      m_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        m_re_d = rs_re;
        m_im_d = rs_im;
      end
    end
  end

  // Status reacts when a saturated beat lands in the output register; it beats a clear.
  assign ovf_evt = en && s1_valid_q && (ovf_re || ovf_im);

  always_comb begin
    sticky_d = sticky_q;
    if (ovf_evt) begin
      sticky_d = 1'b1;
    end else if (ovf_clear) begin
      sticky_d = 1'b0;
    end
  end

`ifdef FFT_TOP_REQUANT_OVF_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ovf_evt) begin
      if (ovf_clear) begin
        cnt_d = CNT_WIDTH'(1);
      end else if (!(&cnt_q)) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end else if (ovf_clear) begin
      cnt_d = '0;
    end
  end

  assign ovf_count = cnt_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      m_valid_q  <= 1'b0;
      m_re_q     <= '0;
      m_im_q     <= '0;
      sticky_q   <= 1'b0;
`ifdef FFT_TOP_REQUANT_OVF_CNT_EN
      cnt_q      <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_re_q    <= s1_re_d;
      s1_im_q    <= s1_im_d;
      m_valid_q  <= m_valid_d;
      m_re_q     <= m_re_d;
      m_im_q     <= m_im_d;
      sticky_q   <= sticky_d;
`ifdef FFT_TOP_REQUANT_OVF_CNT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign m_valid    = m_valid_q;
  assign m_re       = m_re_q;
  assign m_im       = m_im_q;
  assign ovf_sticky = sticky_q;

endmodule
